// File: rtl/bc_skid_pkg.sv
// Shared types for the two-entry clear/enable skid slice.
// Occupancy state and helpers used by the slice and its registers.
package bc_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int RST_NONE     = 0;
  localparam int RST_SYNC_HI  = 1;
  localparam int RST_SYNC_LO  = 2;

  function automatic logic [1:0] occ(
    input skid_state_t s
  );
    logic [1:0] c;
    unique case (s)
      EMPTY:   c = 2'd0;
      BUSY:    c = 2'd1;
      FULL:    c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bc_clr_en_skid_slice_if.sv
// Handshake bundle between producer, skid slice and consumer.
// slave = slice side, master = the surrounding stages.
interface bc_clr_en_skid_slice_if #(
  parameter int WIDTH = 32
);

  logic             iFlush;
  logic             iVld;
  logic             oRdy;
  logic [WIDTH-1:0] iDat;
  logic             oVld;
  logic             iRdy;
  logic [WIDTH-1:0] oDat;
  logic [1:0]       oCnt;

  modport slave (
    input  iFlush,
    input  iVld,
    input  iDat,
    input  iRdy,
    output oRdy,
    output oVld,
    output oDat,
    output oCnt
  );

  modport master (
    output iFlush,
    output iVld,
    output iDat,
    output iRdy,
    input  oRdy,
    input  oVld,
    input  oDat,
    input  oCnt
  );

endinterface

// File: rtl/bc_clr_en_skid_slice_dff.sv
// Library data register with clear and enable; clear wins over enable.
// RST_CFG selects none / sync active-high / sync active-low reset.
module BcClrEnRcDff
  import bc_skid_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = '0,
  parameter int               RST_CFG  = RST_SYNC_LO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (iClr) begin
      q_d = INI_DATA;
    end else if (iEn) begin
      q_d = iD;
    end
  end

  generate
    if (RST_CFG == RST_SYNC_LO) begin : g_lo
      always_ff @(posedge clk) begin
        if (!rst) q_q <= INI_DATA;
        else      q_q <= q_d;
      end
    end else if (RST_CFG == RST_SYNC_HI) begin : g_hi
      always_ff @(posedge clk) begin
        if (rst) q_q <= INI_DATA;
        else     q_q <= q_d;
      end
    end else begin : g_none
      always_ff @(posedge clk) begin
        q_q <= q_d;
      end
    end
  endgenerate

  assign oQ = q_q;

endmodule

// File: rtl/bc_clr_en_skid_slice.sv
// Two-entry valid/ready register slice with synchronous flush.
// All outputs registered; main holds the head beat, skid the second.
module bc_clr_en_skid_slice
  import bc_skid_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  bc_clr_en_skid_slice_if.slave   bus
);

  skid_state_t state_q, state_d;
  logic        vld_q, vld_d;
  logic        rdy_q, rdy_d;
  logic [1:0]  cnt_q, cnt_d;

  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             main_sel_skid;
  logic             main_drain;
  logic             skid_en;
  logic             skid_drain;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign in_fire  = bus.iVld & rdy_q;
  assign out_fire = vld_q & bus.iRdy;

  always_comb begin
    state_d       = state_q;
    main_en       = 1'b0;
    main_sel_skid = 1'b0;
    main_drain    = 1'b0;
    skid_en       = 1'b0;
    skid_drain    = 1'b0;
    if (bus.iFlush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            main_en = 1'b1;
          end
        end
        BUSY: begin
          unique case (1'b1)
            in_fire & ~out_fire: begin
              state_d = FULL;
              skid_en = 1'b1;
            end
            ~in_fire & out_fire: begin
              state_d    = EMPTY;
              main_drain = 1'b1;
            end
            in_fire & out_fire: begin
              main_en = 1'b1;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (out_fire) begin
            state_d       = BUSY;
            main_en       = 1'b1;
            main_sel_skid = 1'b1;
            skid_drain    = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    vld_d = (state_d != EMPTY);
    rdy_d = (state_d != FULL);
    cnt_d = occ(state_d);
  end

  assign main_d = main_sel_skid ? skid_q : bus.iDat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  BcClrEnRcDff #(
    .WIDTH    (WIDTH),
    .INI_DATA (INI_DATA),
    .RST_CFG  (RST_SYNC_LO)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .iClr (bus.iFlush | main_drain),
    .iEn  (main_en),
    .iD   (main_d),
    .oQ   (main_q)
  );

  BcClrEnRcDff #(
    .WIDTH    (WIDTH),
    .INI_DATA (INI_DATA),
    .RST_CFG  (RST_SYNC_LO)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .iClr (bus.iFlush | skid_drain),
    .iEn  (skid_en),
    .iD   (bus.iDat),
    .oQ   (skid_q)
  );

  assign bus.oVld = vld_q;
  assign bus.oRdy = rdy_q;
  assign bus.oCnt = cnt_q;
  assign bus.oDat = main_q;

endmodule

// File: tb/tb_bc_clr_en_skid_slice.sv
// Bench for bc_clr_en_skid_slice: directed cases plus random traffic
// checked against a FIFO queue model of at most two beats.
module tb_bc_clr_en_skid_slice;

  localparam logic [31:0] INI = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bc_clr_en_skid_slice_if #(.WIDTH(32)) bus ();

  bc_clr_en_skid_slice #(
    .WIDTH    (32),
    .INI_DATA (INI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mq[$];
  bit          m_rdy = 1'b0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance model at the edge, check outputs.
  task automatic cyc(
    input bit          r,
    input bit          f,
    input bit          v,
    input bit          rd,
    input logic [31:0] d
  );
    bit inf;
    bit outf;
    rst        = r;
    bus.iFlush = f;
    bus.iVld   = v;
    bus.iRdy   = rd;
    bus.iDat   = d;
    inf  = v && m_rdy;
    outf = (mq.size() != 0) && rd;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_rdy = 1'b0;
    end else if (f) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf)  mq.push_back(d);
      m_rdy = (mq.size() < 2);
    end
    #1;
    chk("cnt", 32'(bus.oCnt), 32'(mq.size()));
    chk("vld", 32'(bus.oVld), (mq.size() != 0) ? 1 : 0);
    chk("rdy", 32'(bus.oRdy), 32'(m_rdy));
    chk("dat", bus.oDat, (mq.size() != 0) ? mq[0] : INI);
  endtask

  initial begin
    // reset with traffic present
    cyc(0, 0, 1, 0, 32'hA5);
    cyc(0, 0, 1, 0, 32'hA5);
    chk("rst_dat", bus.oDat, INI);
    chk("rst_rdy", 32'(bus.oRdy), 0);
    cyc(1, 0, 0, 0, 0);
    chk("rel_rdy", 32'(bus.oRdy), 1);

    // streaming
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 1, 1, 32'(i));
      chk("str_dat", bus.oDat, 32'(i));
    end
    cyc(1, 0, 0, 1, 0);

    // backpressure
    cyc(1, 0, 1, 0, 32'h11);
    cyc(1, 0, 1, 0, 32'h22);
    cyc(1, 0, 1, 0, 32'h99);
    chk("bp_cnt", 32'(bus.oCnt), 2);
    chk("bp_dat", bus.oDat, 32'h11);
    cyc(1, 0, 0, 1, 0);
    chk("bp_nxt", bus.oDat, 32'h22);
    cyc(1, 0, 0, 1, 0);
    chk("bp_end", 32'(bus.oVld), 0);

    // flush while full, with a beat offered
    cyc(1, 0, 1, 0, 32'h44);
    cyc(1, 0, 1, 0, 32'h55);
    cyc(1, 1, 1, 0, 32'h33);
    chk("fl_dat", bus.oDat, INI);
    chk("fl_rdy", 32'(bus.oRdy), 1);
    cyc(1, 0, 0, 1, 0);

    // reset while full
    cyc(1, 0, 1, 0, 32'h66);
    cyc(1, 0, 1, 0, 32'h77);
    cyc(0, 0, 1, 1, 32'h88);
    chk("mr_cnt", 32'(bus.oCnt), 0);
    cyc(1, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(1,
          $urandom_range(15) == 0,
          $urandom_range(1) == 1,
          $urandom_range(1) == 1,
          $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
